// File: rtl/vc_input_unit_pkg.sv
// Shared NoC types for the VC input unit: flit layout, flit/FSM enums, width helpers.
package params_noc;

  localparam int NUM_VC_DEF   = 2;
  localparam int PORT_NUM_DEF = 5;
  localparam int DATA_W       = 16;

  // Width of an index field; a single-entry range still needs one bit.
  function automatic int clog2w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int VC_W   = clog2w(NUM_VC_DEF);
  localparam int PORT_W = clog2w(PORT_NUM_DEF);

  typedef enum logic [1:0] {HEAD, BODY, TAIL, HEADTAIL} flit_type_e;
  typedef enum logic [1:0] {IDLE, VA, ACTIVE} vc_state_e;

  typedef struct packed {
    flit_type_e          ftype;
    logic [PORT_W-1:0]   dest;
    logic [DATA_W-1:0]   payload;
  } flit_t;

endpackage

// File: rtl/vc_input_unit_if.sv
// Upstream/allocator-facing bundle of the VC input unit.
interface vc_input_unit_if
  import params_noc::*;
#(
  parameter int NUM_VC   = 2,
  parameter int PORT_NUM = 5
);
  localparam int VCW = clog2w(NUM_VC);
  localparam int PW  = clog2w(PORT_NUM);

  logic                         write_i;
  logic [VCW-1:0]               write_vc_i;
  flit_t                        flit_i;
  logic [NUM_VC-1:0]            read_i;
  flit_t                        flit_o;
  logic [NUM_VC-1:0]            vc_alloc_i;
  logic [NUM_VC-1:0][VCW-1:0]   downstream_vc_i;
  logic [NUM_VC-1:0]            vc_req_o;
  logic [NUM_VC-1:0]            switch_req_o;
  logic [NUM_VC-1:0][PW-1:0]    port_o;
  logic [NUM_VC-1:0][VCW-1:0]   downstream_vc_o;
  logic [NUM_VC-1:0]            buf_full_o;
  logic [NUM_VC-1:0]            buf_empty_o;
  logic [NUM_VC-1:0]            credit_o;
  logic [NUM_VC-1:0]            err_o;

  modport master (
    output write_i, write_vc_i, flit_i, read_i, vc_alloc_i, downstream_vc_i,
    input  flit_o, vc_req_o, switch_req_o, port_o, downstream_vc_o,
           buf_full_o, buf_empty_o, credit_o, err_o
  );

  modport slave (
    input  write_i, write_vc_i, flit_i, read_i, vc_alloc_i, downstream_vc_i,
    output flit_o, vc_req_o, switch_req_o, port_o, downstream_vc_o,
           buf_full_o, buf_empty_o, credit_o, err_o
  );

endinterface

// File: rtl/vc_input_unit_fifo.sv
// Per-VC flit FIFO; head is visible combinationally, push/pop are pre-qualified by the caller.
module vc_fifo
  import params_noc::*;
#(
  parameter int BUFFER_SIZE = 8
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  i_push,
  input  logic  i_pop,
  input  flit_t i_data,
  output flit_t o_head,
  output logic  o_full,
  output logic  o_empty
);
  localparam int AW = $clog2(BUFFER_SIZE);

  flit_t          r_mem [BUFFER_SIZE];
  logic [AW-1:0]  r_wr_ptr;
  logic [AW-1:0]  r_rd_ptr;
  logic [AW:0]    r_count;

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_full  = (r_count == (AW+1)'(BUFFER_SIZE));
  assign o_empty = (r_count == '0);

endmodule

// File: rtl/vc_input_unit.sv
// Router input port: one FIFO and one packet FSM per virtual channel, with sticky protocol errors.
//   state  | meaning
//   IDLE   | waiting for a HEAD/HEADTAIL at the FIFO head; stray BODY/TAIL flits are dropped
//   VA     | requesting a downstream VC
//   ACTIVE | downstream VC owned; flits forwarded on switch grant until the tail leaves
module vc_input_unit
  import params_noc::*;
#(
  parameter int NUM_VC      = 2,
  parameter int BUFFER_SIZE = 8,
  parameter int PORT_NUM    = 5
) (
  input logic            clk,
  input logic            rst_n,
  vc_input_unit_if.slave bus
);
  localparam int VCW = clog2w(NUM_VC);
  localparam int PW  = clog2w(PORT_NUM);

  flit_t             w_head [NUM_VC];
  logic [NUM_VC-1:0] w_full;
  logic [NUM_VC-1:0] w_empty;
  logic              w_read_onehot;

  assign w_read_onehot = (bus.read_i != '0) &&
                         ((bus.read_i & (bus.read_i - NUM_VC'(1))) == '0);

  always_comb begin
    bus.flit_o = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      if (bus.read_i[v]) bus.flit_o = w_head[v];
    end
  end

  for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
    vc_state_e       r_state;
    logic [PW-1:0]   r_port;
    logic [VCW-1:0]  r_dvc;
    logic            r_err;
    logic            r_credit;
    logic            w_write_hit, w_push, w_rd_ok, w_discard, w_pop, w_err_set;
    logic            w_head_start, w_head_end;

    assign w_head_start = (w_head[v].ftype == HEAD) || (w_head[v].ftype == HEADTAIL);
    assign w_head_end   = (w_head[v].ftype == TAIL) || (w_head[v].ftype == HEADTAIL);
    assign w_write_hit  = bus.write_i && (bus.write_vc_i == VCW'(v));
    assign w_push       = w_write_hit && !w_full[v];
    assign w_rd_ok      = bus.read_i[v] && w_read_onehot && (r_state == ACTIVE) && !w_empty[v];
    assign w_discard    = (r_state == IDLE) && !w_empty[v] && !w_head_start;
    assign w_pop        = w_rd_ok || w_discard;
    // A refused read, a write into a full FIFO, a stray grant or an orphan flit all flag the VC.
    assign w_err_set    = (w_write_hit && w_full[v]) || (bus.read_i[v] && !w_rd_ok) ||
                          (bus.vc_alloc_i[v] && (r_state != VA)) || w_discard;

    vc_fifo #(.BUFFER_SIZE(BUFFER_SIZE)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_data  (bus.flit_i),
      .o_head  (w_head[v]),
      .o_full  (w_full[v]),
      .o_empty (w_empty[v])
    );

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_state  <= IDLE;
        r_port   <= '0;
        r_dvc    <= '0;
        r_err    <= 1'b0;
        r_credit <= 1'b0;
      end else begin
        r_err    <= r_err | w_err_set;
        r_credit <= w_pop;
        case (r_state)
          IDLE: begin
            if (!w_empty[v] && w_head_start) begin
              r_state <= VA;
              r_port  <= PW'(w_head[v].dest);
            end
          end
          VA: begin
            if (bus.vc_alloc_i[v]) begin
              r_dvc   <= bus.downstream_vc_i[v];
              r_state <= ACTIVE;
            end
          end
          ACTIVE: begin
            if (w_rd_ok && w_head_end) r_state <= IDLE;
          end
          default: r_state <= IDLE;
        endcase
      end
    end

    assign bus.vc_req_o[v]        = (r_state == VA);
    assign bus.switch_req_o[v]    = (r_state == ACTIVE) && !w_empty[v];
    assign bus.port_o[v]          = r_port;
    assign bus.downstream_vc_o[v] = r_dvc;
    assign bus.err_o[v]           = r_err;
    assign bus.credit_o[v]        = r_credit;
  end

  assign bus.buf_full_o  = w_full;
  assign bus.buf_empty_o = w_empty;

endmodule
